// File: rtl/minsec_stop_pkg.sv
// Shared definitions for the MM:SS.CC stopwatch time-base counter.
package minsec_stop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int TICKS_PER_CS_DEF = 10;
  localparam int CS_MAX_DEF       = 100;
  localparam int SEC_MAX_DEF      = 60;
  localparam int MIN_MAX_DEF      = 60;

  localparam int CS_W  = 7;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;

endpackage

// File: rtl/minsec_stop_counter_if.sv
// Control pulses in, MM:SS.CC time and status out.
interface minsec_stop_counter_if;
  import minsec_stop_pkg::*;

  logic             i_tick;
  logic             i_run_stop;
  logic             i_clear;
  logic [CS_W-1:0]  o_cs;
  logic [SEC_W-1:0] o_sec;
  logic [MIN_W-1:0] o_min;
  logic             o_running;
  logic             o_rollover;

  // Driver side: tick generator and debounced buttons.
  modport master (
    output i_tick, i_run_stop, i_clear,
    input  o_cs, o_sec, o_min, o_running, o_rollover
  );

  // Counter side.
  modport slave (
    input  i_tick, i_run_stop, i_clear,
    output o_cs, o_sec, o_min, o_running, o_rollover
  );
endinterface

// File: rtl/minsec_stop_mod_counter.sv
// Generic modulo-N counter: synchronous clear, count enable, and a
// combinational carry so a chain of these settles within one edge.
module minsec_stop_mod_counter #(
  parameter int MODULUS = 10,
  parameter int W       = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         carry
);
  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  // Carry is raised on the enabled step that wraps LAST back to zero.
  assign carry = en && (count == LAST);

  // Count register: clear has priority over enable.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is written with <= only, so every register in the chain
    // samples the pre-edge values and the cascade cannot race.
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= (count == LAST) ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/minsec_stop_counter.sv
// Stopwatch time base: run/stop/clear FSM plus a prescaler -> cs -> sec
// -> min counter cascade, with a one-cycle pulse on wrap to 00:00.00.
module minsec_stop_counter
  import minsec_stop_pkg::*;
#(
  parameter int TICKS_PER_CS = TICKS_PER_CS_DEF,
  parameter int CS_MAX       = CS_MAX_DEF,
  parameter int SEC_MAX      = SEC_MAX_DEF,
  parameter int MIN_MAX      = MIN_MAX_DEF
) (
  input logic                 clk,
  input logic                 reset,
  minsec_stop_counter_if.slave bus
);
  localparam int PRE_W = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;

  state_t           state;
  logic             running_q;
  logic             rollover_q;
  logic             count_en;
  logic             clear_cnt;
  logic [PRE_W-1:0] pre_count;
  logic [CS_W-1:0]  cs_count;
  logic [SEC_W-1:0] sec_count;
  logic [MIN_W-1:0] min_count;
  logic             pre_carry;
  logic             cs_carry;
  logic             sec_carry;
  logic             min_carry;

  // Gating uses the registered state, so a tick on the edge entering RUN is
  // dropped and a tick on the edge leaving RUN is kept.
  assign count_en  = (state == RUN) && bus.i_tick;
  assign clear_cnt = (state == STOP) && bus.i_clear;

  minsec_stop_mod_counter #(.MODULUS(TICKS_PER_CS), .W(PRE_W)) u_pre (
    .clk(clk), .reset(reset), .clear(clear_cnt), .en(count_en),
    .count(pre_count), .carry(pre_carry)
  );

  minsec_stop_mod_counter #(.MODULUS(CS_MAX), .W(CS_W)) u_cs (
    .clk(clk), .reset(reset), .clear(clear_cnt), .en(pre_carry),
    .count(cs_count), .carry(cs_carry)
  );

  minsec_stop_mod_counter #(.MODULUS(SEC_MAX), .W(SEC_W)) u_sec (
    .clk(clk), .reset(reset), .clear(clear_cnt), .en(cs_carry),
    .count(sec_count), .carry(sec_carry)
  );

  minsec_stop_mod_counter #(.MODULUS(MIN_MAX), .W(MIN_W)) u_min (
    .clk(clk), .reset(reset), .clear(clear_cnt), .en(sec_carry),
    .count(min_count), .carry(min_carry)
  );

  // Control FSM; o_running is registered alongside the state it mirrors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      running_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_run_stop) begin
          state     <= RUN;
          running_q <= 1'b1;
        end
        RUN: if (bus.i_run_stop) begin
          state     <= STOP;
          running_q <= 1'b0;
        end
        STOP: if (bus.i_clear) begin
          state     <= IDLE;
          running_q <= 1'b0;
        end else if (bus.i_run_stop) begin
          state     <= RUN;
          running_q <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Rollover pulse lands on the same edge the counters show 00:00.00.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rollover_q <= 1'b0;
    else       rollover_q <= min_carry;
  end

  assign bus.o_cs       = cs_count;
  assign bus.o_sec      = sec_count;
  assign bus.o_min      = min_count;
  assign bus.o_running  = running_q;
  assign bus.o_rollover = rollover_q;

  // Counter range guards.
  a_pre_range : assert property (@(posedge clk) disable iff (reset)
    int'(pre_count) < TICKS_PER_CS);
  a_cs_range  : assert property (@(posedge clk) disable iff (reset)
    int'(cs_count) < CS_MAX);
  a_sec_range : assert property (@(posedge clk) disable iff (reset)
    int'(sec_count) < SEC_MAX);
  a_min_range : assert property (@(posedge clk) disable iff (reset)
    int'(min_count) < MIN_MAX);
endmodule

// File: doc/minsec_stop_counter.md
Name: minsec_stop_counter

Overview:
- Stopwatch time-base counter, directly downstream of the 1 kHz stopwatch tick generator.
- Consumes the 1 ms single-cycle tick and maintains centiseconds, seconds and minutes (MM:SS.CC).
- Run/stop/clear control comes from debounced single-cycle button pulses; the control FSM lives in this block.
- Outputs feed the FND display formatter.

Parameters:
- TICKS_PER_CS, default 10: i_tick pulses per centisecond.
- CS_MAX, default 100: centisecond modulus.
- SEC_MAX, default 60: second modulus.
- MIN_MAX, default 60: minute modulus.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high.
- i_tick  in  1  1 kHz tick, one clk cycle high per period.
- i_run_stop  in  1  single-cycle pulse; toggles run/stop.
- i_clear  in  1  single-cycle pulse; zeroes the time when stopped.
- o_cs  out  7  centiseconds, 0..CS_MAX-1.
- o_sec  out  6  seconds, 0..SEC_MAX-1.
- o_min  out  6  minutes, 0..MIN_MAX-1.
- o_running  out  1  high while state is RUN.
- o_rollover  out  1  one-cycle pulse on wrap from MIN_MAX-1:SEC_MAX-1.CS_MAX-1 to 00:00.00.

Behaviour:
Clock and reset:
- Clock clk; reset is asynchronous, active-high.
- On reset: state=IDLE, prescaler=0, o_cs=0, o_sec=0, o_min=0, o_running=0, o_rollover=0.
- Reset mid-count aborts immediately to these values.

FSM states IDLE, RUN, STOP. One transition per clk edge; priority listed highest first.
- IDLE: i_run_stop -> RUN. i_clear is a no-op. Counters are held at 0.
- RUN: i_run_stop -> STOP. i_clear is ignored (no effect on state or counters).
- STOP: i_clear -> IDLE, zeroing prescaler and all counters on the same edge. Else i_run_stop -> RUN (resume from held value).
- STOP with i_clear and i_run_stop in the same cycle: clear wins.

Counting:
- Counting is gated by the current (registered) state == RUN.
- i_tick sampled high on the same edge that leaves IDLE/STOP for RUN is NOT counted.
- i_tick sampled high on the same edge that leaves RUN for STOP IS counted.
- Prescaler 0..TICKS_PER_CS-1, advanced by each counted tick.
- When the prescaler is at TICKS_PER_CS-1 and a tick is counted: prescaler->0 and cs increments.
- Cascade: cs wraps CS_MAX-1->0 and carries into sec; sec wraps SEC_MAX-1->0 and carries into min; min wraps MIN_MAX-1->0 and raises o_rollover for exactly that cycle.
- Counting continues after rollover; there is no auto-stop.
- The prescaler is retained across STOP/RUN, so sub-centisecond time is not lost on resume.

Output timing:
- o_cs, o_sec, o_min and o_running are registered.
- A counted tick at edge N becomes visible after edge N (latency 1 clk from tick sampling).
- All carries settle in the same edge; there is never an intermediate value such as 00:60.00 on the outputs.
- o_rollover is registered and aligned with the 00:00.00 value.
- Pulse inputs are assumed synchronous single-cycle. A level held high re-triggers every cycle; that is the caller's responsibility.

Decomposition:
- Shared package minsec_stop_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, STOP=2'd2;
  - default moduli constants;
  - widths CS_W=7, SEC_W=6, MIN_W=6.
- Natural sub-module: minsec_stop_mod_counter (generic modulo-N counter with enable in, carry out). Instantiate it 4 times: prescaler, cs, sec, min.
- The FSM and rollover logic stay in the top.

Test Plan:
- Reset, then 25 ticks with no run pulse -> outputs stay 00:00.00, o_running=0.
- run_stop pulse, then 1234 ticks -> o_min=0, o_sec=1, o_cs=23, o_running=1; prescaler mid-count.
- In RUN, run_stop and i_tick in the same cycle -> tick counted, then state STOP. Next 50 ticks -> no change. run_stop again, then 10 ticks -> cs advances by exactly 1.
- Set running time to 59:59.99 with prescaler 9, then 1 tick -> 00:00.00, o_rollover high exactly 1 cycle, still RUN.
- In STOP at 00:03.50: i_clear and i_run_stop in the same cycle -> IDLE, 00:00.00. In RUN: i_clear -> ignored, time keeps counting.
- Assert reset mid-RUN at 01:02.03 -> all outputs 0 asynchronously. After release, 10 ticks -> still 00:00.00 (IDLE).
